// File: rtl/cmn_valrdy_queue.sv
`default_nettype none
// ============================================================================
// Module   : cmn_valrdy_queue
// Brief    : Parameterised "normal" valid/ready FIFO. It has registered
//            outputs and no enq->deq or deq_rdy->enq_rdy combinational path.
// Revision : 1.0  initial release
// ============================================================================
module cmn_valrdy_queue #(
    parameter int p_nbits       = 32,
    parameter int p_num_entries = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enq_val,
    output logic                                   enq_rdy,
    input  logic [p_nbits-1:0]                     enq_msg,
    output logic                                   deq_val,
    input  logic                                   deq_rdy,
    output logic [p_nbits-1:0]                     deq_msg,
    output logic [$clog2(p_num_entries+1)-1:0]     num_free_entries
);

    localparam int c_PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int c_CNT_W = $clog2(p_num_entries + 1);

    logic [p_nbits-1:0] r_storage [0:p_num_entries-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_enq_fire;
    logic               w_deq_fire;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    // Handshake status depends on registered occupancy only.
    assign enq_rdy          = (r_count != c_CNT_W'(p_num_entries));
    assign deq_val          = (r_count != '0);
    assign deq_msg          = r_storage[r_rd_ptr];
    assign num_free_entries = c_CNT_W'(p_num_entries) - r_count;

    assign w_enq_fire = enq_val && enq_rdy;
    assign w_deq_fire = deq_val && deq_rdy;

    // Explicit wrap so that non-power-of-two depths work.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_W'(p_num_entries - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_W'(p_num_entries - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_enq_fire && !w_deq_fire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq_fire && w_deq_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers and the count define validity.
    always_ff @(posedge clk) begin
        if (!reset && w_enq_fire) begin
            r_storage[r_wr_ptr] <= enq_msg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmn_valrdy_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmn_valrdy_queue
// Brief    : Self-checking bench for cmn_valrdy_queue (depth 2 and depth 3).
// Revision : 1.0  initial release
// ============================================================================
module tb_cmn_valrdy_queue;

    logic        clk;
    logic        reset;

    logic        enq_val2, enq_rdy2, deq_val2, deq_rdy2;
    logic [31:0] enq_msg2, deq_msg2;
    logic [1:0]  free2;

    logic        enq_val3, enq_rdy3, deq_val3, deq_rdy3;
    logic [31:0] enq_msg3, deq_msg3;
    logic [1:0]  free3;

    int vectors;
    int miscompares;

    // Reference contents: index 0 is the head of the queue.
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    cmn_valrdy_queue #(.p_nbits(32), .p_num_entries(2)) dut2 (
        .clk(clk), .reset(reset),
        .enq_val(enq_val2), .enq_rdy(enq_rdy2), .enq_msg(enq_msg2),
        .deq_val(deq_val2), .deq_rdy(deq_rdy2), .deq_msg(deq_msg2),
        .num_free_entries(free2)
    );

    cmn_valrdy_queue #(.p_nbits(32), .p_num_entries(3)) dut3 (
        .clk(clk), .reset(reset),
        .enq_val(enq_val3), .enq_rdy(enq_rdy3), .enq_msg(enq_msg3),
        .deq_val(deq_val3), .deq_rdy(deq_rdy3), .deq_msg(deq_msg3),
        .num_free_entries(free3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and apply the queue rules to the reference model.
    task automatic tick();
        bit e2, d2, e3, d3;
        @(posedge clk);
        e2 = enq_val2 && (q2.size() < 2);
        d2 = deq_rdy2 && (q2.size() > 0);
        e3 = enq_val3 && (q3.size() < 3);
        d3 = deq_rdy3 && (q3.size() > 0);
        if (reset) begin
            q2.delete();
            q3.delete();
        end else begin
            if (d2) void'(q2.pop_front());
            if (e2) q2.push_back(enq_msg2);
            if (d3) void'(q3.pop_front());
            if (e3) q3.push_back(enq_msg3);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (enq_rdy3 !== 1'b1 || deq_val3 !== 1'b0 || free3 !== 2'd3) begin
            miscompares++;
            $display("FAIL reset_d3: rdy=%b val=%b free=%0d, want rdy=1 val=0 free=3",
                     enq_rdy3, deq_val3, free3);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (enq_rdy2 !== 1'b1 || deq_val2 !== 1'b0 || free2 !== 2'd2) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: rdy=%b val=%b free=%0d, want rdy=1 val=0 free=2",
                         i, enq_rdy2, deq_val2, free2);
            end
            tick();
        end
    endtask

    task automatic test_single();
        enq_val2 = 1'b1;
        enq_msg2 = 32'hDEADBEEF;
        deq_rdy2 = 1'b1;
        vectors++;
        if (deq_val2 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_bypass: deq_val=%b, want 0", deq_val2);
        end
        tick();
        enq_val2 = 1'b0;
        enq_msg2 = 32'h0;
        vectors++;
        if (deq_val2 !== 1'b1 || deq_msg2 !== 32'hDEADBEEF || free2 !== 2'd1) begin
            miscompares++;
            $display("FAIL single_visible: val=%b msg=%h free=%0d, want val=1 msg=deadbeef free=1",
                     deq_val2, deq_msg2, free2);
        end
        tick();
        vectors++;
        if (deq_val2 !== 1'b0 || free2 !== 2'd2) begin
            miscompares++;
            $display("FAIL single_drained: val=%b free=%0d, want val=0 free=2", deq_val2, free2);
        end
        deq_rdy2 = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] exp_order [3];
        exp_order[0] = 32'h1;
        exp_order[1] = 32'h2;
        exp_order[2] = 32'h3;
        deq_rdy2 = 1'b0;
        enq_val2 = 1'b1;
        enq_msg2 = 32'h1;
        tick();
        enq_msg2 = 32'h2;
        tick();
        vectors++;
        if (enq_rdy2 !== 1'b0 || free2 !== 2'd0 || deq_msg2 !== 32'h1) begin
            miscompares++;
            $display("FAIL fill_full: rdy=%b free=%0d head=%h, want rdy=0 free=0 head=1",
                     enq_rdy2, free2, deq_msg2);
        end
        // Enq while full must be dropped even though a deq fires the same edge.
        enq_msg2 = 32'h3;
        deq_rdy2 = 1'b1;
        tick();
        deq_rdy2 = 1'b0;
        vectors++;
        if (enq_rdy2 !== 1'b1 || free2 !== 2'd1 || deq_msg2 !== 32'h2) begin
            miscompares++;
            $display("FAIL fill_full_enq_ignored: rdy=%b free=%0d head=%h, want rdy=1 free=1 head=2",
                     enq_rdy2, free2, deq_msg2);
        end
        tick();
        enq_val2 = 1'b0;
        deq_rdy2 = 1'b1;
        for (int i = 1; i < 3; i++) begin
            vectors++;
            if (deq_val2 !== 1'b1 || deq_msg2 !== exp_order[i]) begin
                miscompares++;
                $display("FAIL fill_drain[%0d]: val=%b msg=%h, want val=1 msg=%h",
                         i, deq_val2, deq_msg2, exp_order[i]);
            end
            tick();
        end
        vectors++;
        if (deq_val2 !== 1'b0 || free2 !== 2'd2) begin
            miscompares++;
            $display("FAIL fill_empty: val=%b free=%0d, want val=0 free=2", deq_val2, free2);
        end
        deq_rdy2 = 1'b0;
    endtask

    task automatic test_streaming();
        int tx = 0;
        int rx = 0;
        int cycles = 0;
        while (rx < 100 && cycles < 3000) begin
            enq_val3 = (tx < 100) && ($urandom_range(0, 99) < 70);
            enq_msg3 = tx;
            deq_rdy3 = ($urandom_range(0, 99) < 60);
            vectors++;
            if (deq_val3 !== (q3.size() > 0) || enq_rdy3 !== (q3.size() < 3) ||
                free3 !== 2'(3 - q3.size()) || free3 > 2'd3) begin
                miscompares++;
                $display("FAIL stream_status[%0d]: val=%b rdy=%b free=%0d, want val=%b rdy=%b free=%0d",
                         cycles, deq_val3, enq_rdy3, free3, q3.size() > 0, q3.size() < 3, 3 - q3.size());
            end
            if (deq_rdy3 && q3.size() > 0) begin
                vectors++;
                if (deq_msg3 !== 32'(rx)) begin
                    miscompares++;
                    $display("FAIL stream_order[%0d]: msg=%0d, want %0d", rx, deq_msg3, rx);
                end
                rx++;
            end
            if (enq_val3 && q3.size() < 3) tx++;
            tick();
            cycles++;
        end
        enq_val3 = 1'b0;
        deq_rdy3 = 1'b0;
        vectors++;
        if (rx != 100) begin
            miscompares++;
            $display("FAIL stream_timeout: received %0d, want 100", rx);
        end
    endtask

    task automatic test_back_to_back();
        int rx = 1000;
        enq_val2 = 1'b1;
        deq_rdy2 = 1'b1;
        enq_msg2 = 32'd1000;
        tick();
        for (int i = 0; i < 50; i++) begin
            enq_msg2 = 32'(1001 + i);
            vectors++;
            if (deq_val2 !== 1'b1 || enq_rdy2 !== 1'b1 || deq_msg2 !== 32'(rx)) begin
                miscompares++;
                $display("FAIL b2b[%0d]: val=%b rdy=%b msg=%0d, want val=1 rdy=1 msg=%0d",
                         i, deq_val2, enq_rdy2, deq_msg2, rx);
            end
            rx++;
            tick();
        end
        enq_val2 = 1'b0;
        deq_rdy2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        // One message remains from the back-to-back run; add one more.
        enq_val2 = 1'b1;
        enq_msg2 = 32'h5555_0001;
        tick();
        vectors++;
        if (free2 !== 2'd0 || deq_val2 !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_full: free=%0d val=%b, want free=0 val=1", free2, deq_val2);
        end
        enq_msg2 = 32'h0BAD_0BAD;
        deq_rdy2 = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enq_val2 = 1'b0;
        deq_rdy2 = 1'b0;
        vectors++;
        if (deq_val2 !== 1'b0 || free2 !== 2'd2 || enq_rdy2 !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_cleared: val=%b free=%0d rdy=%b, want val=0 free=2 rdy=1",
                     deq_val2, free2, enq_rdy2);
        end
        tick();
        vectors++;
        if (deq_val2 !== 1'b0 || free2 !== 2'd2) begin
            miscompares++;
            $display("FAIL rstmid_not_stored: val=%b free=%0d, want val=0 free=2", deq_val2, free2);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        enq_val2 = 1'b0; deq_rdy2 = 1'b0; enq_msg2 = '0;
        enq_val3 = 1'b0; deq_rdy3 = 1'b0; enq_msg3 = '0;
        test_reset();
        test_single();
        test_fill();
        test_streaming();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
